// File: rtl/mux_out_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_out_glitch_filter
//  Description : Glitch filter for the output of a gate-level 2->1 mux. The raw
//                output is synchronised into the clk domain. A new level is
//                accepted only after STABLE_CYCLES consecutive equal synced
//                samples. Every accepted change produces a one-cycle edge
//                pulse. Rejected excursions are counted in a saturating counter.
//  Ports       : clk        - single clock, all state changes on posedge
//                rst        - synchronous active-high reset
//                z_in       - raw mux output, asynchronous to clk
//                glitch_clr - synchronous clear of glitch_cnt / glitch_sat
//                filt_out   - filtered, registered level
//                rise_pulse - one-cycle pulse on an accepted 0->1
//                fall_pulse - one-cycle pulse on an accepted 1->0
//                glitch_cnt - saturating count of rejected pulses
//                glitch_sat - high while glitch_cnt is at its maximum
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_out_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z_in,
  input  logic             glitch_clr,
  output logic             filt_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             glitch_sat
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] C_IDLE_LO = 2'd0;
  localparam logic [1:0] C_PEND_HI = 2'd1;
  localparam logic [1:0] C_IDLE_HI = 2'd2;
  localparam logic [1:0] C_PEND_LO = 2'd3;

  localparam logic [SC_W-1:0]  C_STAB_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0]  C_STAB_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [SC_W-1:0]        stab_cnt_q, stab_cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_W-1:0]       glitch_cnt_q, glitch_cnt_d;
  logic                   glitch_sat_q, glitch_sat_d;
  logic                   w_s;
  logic                   w_glitch_ev;

  // Shift chain: bit 0 captures z_in, the last bit is the synced sample.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], z_in};
  end

  assign w_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    stab_cnt_d  = stab_cnt_q;
    filt_d      = filt_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    w_glitch_ev = 1'b0;
    case (state_q)
      C_IDLE_LO: begin
        if (w_s) begin
          state_d    = C_PEND_HI;
          stab_cnt_d = C_STAB_ONE;
        end
      end
      C_PEND_HI: begin
        if (w_s) begin
          if (stab_cnt_q == C_STAB_LAST) begin
            state_d    = C_IDLE_HI;
            stab_cnt_d = '0;
            filt_d     = 1'b1;
            rise_d     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + C_STAB_ONE;
          end
        end else begin
          // Candidate high level collapsed before it was accepted.
          state_d     = C_IDLE_LO;
          stab_cnt_d  = '0;
          w_glitch_ev = 1'b1;
        end
      end
      C_IDLE_HI: begin
        if (!w_s) begin
          state_d    = C_PEND_LO;
          stab_cnt_d = C_STAB_ONE;
        end
      end
      C_PEND_LO: begin
        if (!w_s) begin
          if (stab_cnt_q == C_STAB_LAST) begin
            state_d    = C_IDLE_LO;
            stab_cnt_d = '0;
            filt_d     = 1'b0;
            fall_d     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + C_STAB_ONE;
          end
        end else begin
          state_d     = C_IDLE_HI;
          stab_cnt_d  = '0;
          w_glitch_ev = 1'b1;
        end
      end
      default: begin
        state_d    = C_IDLE_LO;
        stab_cnt_d = '0;
      end
    endcase
  end

  // Clear has priority over a simultaneous glitch; the count never wraps.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (w_glitch_ev && (glitch_cnt_q != C_CNT_MAX)) begin
      glitch_cnt_d = glitch_cnt_q + C_CNT_ONE;
    end
    glitch_sat_d = (glitch_cnt_d == C_CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= C_IDLE_LO;
      stab_cnt_q   <= '0;
      filt_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_cnt_q <= '0;
      glitch_sat_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      filt_q       <= filt_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      glitch_cnt_q <= glitch_cnt_d;
      glitch_sat_q <= glitch_sat_d;
    end
  end

  assign filt_out   = filt_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign glitch_cnt = glitch_cnt_q;
  assign glitch_sat = glitch_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_out_glitch_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_out_glitch_filter
//  Description : Directed self-checking bench for mux_out_glitch_filter.
//                dut uses default parameters; dut2 uses CNT_W=2 to reach
//                counter saturation quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_out_glitch_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       z_in = 1'b0;
  logic       glitch_clr = 1'b0;
  logic       filt_out, rise_pulse, fall_pulse, glitch_sat;
  logic [7:0] glitch_cnt;

  logic       z2 = 1'b0;
  logic       clr2 = 1'b0;
  logic       filt2, rise2, fall2, sat2;
  logic [1:0] cnt2;

  // Gate-level mux model signals: z = NAND(NAND(d1,sel), NAND(d0,~sel)).
  logic d0 = 1'b1, d1 = 1'b1, sel = 1'b1, nsel = 1'b0, na = 1'b0, nb = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_out_glitch_filter dut (
    .clk        (clk),
    .rst        (rst),
    .z_in       (z_in),
    .glitch_clr (glitch_clr),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .glitch_cnt (glitch_cnt),
    .glitch_sat (glitch_sat)
  );

  mux_out_glitch_filter #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .z_in       (z2),
    .glitch_clr (clr2),
    .filt_out   (filt2),
    .rise_pulse (rise2),
    .fall_pulse (fall2),
    .glitch_cnt (cnt2),
    .glitch_sat (sat2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Short pulse on dut2: s is high for two FSM samples, and the glitch event
  // lands on the fifth edge after the pulse starts; clr2 covers that edge.
  task automatic glitch2(input logic with_clr);
    z2 = 1'b1;
    tick();
    tick();
    z2 = 1'b0;
    tick();
    tick();
    clr2 = with_clr;
    tick();
    clr2 = 1'b0;
    ticks(3);
  endtask

  task automatic set_sel(input logic v);
    sel = v;
    #1 na = ~(d1 & sel);
    z_in = ~(na & nb);
    #1 nsel = ~sel;
    #1 nb = ~(d0 & nsel);
    z_in = ~(na & nb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with z_in high, then release
    z_in = 1'b1;
    rst  = 1'b1;
    ticks(3);
    chk("rst_filt", 32'(filt_out), 32'd0);
    chk("rst_rise", 32'(rise_pulse), 32'd0);
    chk("rst_fall", 32'(fall_pulse), 32'd0);
    chk("rst_cnt",  32'(glitch_cnt), 32'd0);
    chk("rst_sat",  32'(glitch_sat), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("rel_filt", 32'(filt_out), 32'(i >= 6));
      chk("rel_rise", 32'(rise_pulse), 32'(i == 6));
    end

    // 2: clean fall then clean rise, 6 edges latency each
    z_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("fall_filt", 32'(filt_out), 32'(i < 6));
      chk("fall_pls",  32'(fall_pulse), 32'(i == 6));
      chk("fall_rise", 32'(rise_pulse), 32'd0);
    end
    z_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("rise_filt", 32'(filt_out), 32'(i >= 6));
      chk("rise_pls",  32'(rise_pulse), 32'(i == 6));
      chk("rise_fall", 32'(fall_pulse), 32'd0);
    end
    chk("clean_cnt", 32'(glitch_cnt), 32'd0);

    // 3: glitches from IDLE_LO and IDLE_HI
    z_in = 1'b0;
    ticks(10);
    chk("lo_filt", 32'(filt_out), 32'd0);
    z_in = 1'b1;
    ticks(2);
    z_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("g1_filt", 32'(filt_out), 32'd0);
      chk("g1_rise", 32'(rise_pulse), 32'd0);
    end
    chk("g1_cnt", 32'(glitch_cnt), 32'd1);
    z_in = 1'b1;
    ticks(10);
    chk("hi_filt", 32'(filt_out), 32'd1);
    z_in = 1'b0;
    ticks(2);
    z_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("g2_filt", 32'(filt_out), 32'd1);
      chk("g2_fall", 32'(fall_pulse), 32'd0);
    end
    chk("g2_cnt", 32'(glitch_cnt), 32'd2);
    // one sample short of acceptance is still a glitch
    z_in = 1'b0;
    ticks(3);
    z_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("g3_filt", 32'(filt_out), 32'd1);
      chk("g3_fall", 32'(fall_pulse), 32'd0);
    end
    chk("g3_cnt", 32'(glitch_cnt), 32'd3);

    // 4: saturation on the 2-bit counter, then clear racing a glitch
    glitch2(1'b0);
    chk("s1_cnt", 32'(cnt2), 32'd1);
    chk("s1_sat", 32'(sat2), 32'd0);
    glitch2(1'b0);
    glitch2(1'b0);
    chk("s3_cnt", 32'(cnt2), 32'd3);
    chk("s3_sat", 32'(sat2), 32'd1);
    glitch2(1'b0);
    glitch2(1'b0);
    chk("s5_cnt", 32'(cnt2), 32'd3);
    chk("s5_sat", 32'(sat2), 32'd1);
    chk("s5_filt", 32'(filt2), 32'd0);
    glitch2(1'b1);
    chk("clr_cnt", 32'(cnt2), 32'd0);
    chk("clr_sat", 32'(sat2), 32'd0);
    chk("clr_filt", 32'(filt2), 32'd0);

    // 5: reset during the second PEND_HI cycle
    z_in = 1'b0;
    ticks(10);
    chk("p_filt0", 32'(filt_out), 32'd0);
    z_in = 1'b1;
    ticks(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_filt", 32'(filt_out), 32'd0);
    chk("mid_rise", 32'(rise_pulse), 32'd0);
    chk("mid_cnt",  32'(glitch_cnt), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("post_filt", 32'(filt_out), 32'(i >= 6));
      chk("post_rise", 32'(rise_pulse), 32'(i == 6));
      chk("post_cnt",  32'(glitch_cnt), 32'd0);
    end

    // 6: gate-level mux with d0=d1=1 and sel toggling every 40 ns
    d0 = 1'b1; d1 = 1'b1; sel = 1'b1; nsel = 1'b0; na = 1'b0; nb = 1'b1;
    z_in = 1'b1;
    ticks(2);
    @(posedge clk);
    #8;
    fork
      begin
        // 1->0 toggles open a 2 ns low hazard that straddles a posedge
        for (int t = 0; t < 12; t++) begin
          set_sel(~sel);
          #37;
        end
      end
      begin
        for (int c = 0; c < 48; c++) begin
          @(negedge clk);
          chk("mux_filt", 32'(filt_out), 32'd1);
          chk("mux_rise", 32'(rise_pulse), 32'd0);
          chk("mux_fall", 32'(fall_pulse), 32'd0);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
